fpt_channel_scheduler: RTL and testbench

- Time-shares one psi_fpt_core instance among NUM_CH sensor/motor channels in the 250 MHz domain.
- Arbitrates round-robin among valid channels and issues one sample per transaction to the core.
- Waits the fixed core latency, then routes motor_correction and veto back to the granted channel.
- Holds the core idle until DCM lock. Masks vetoed channels until software clears them.

---
 rtl/fpt_channel_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_fpt_channel_scheduler.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpt_channel_scheduler.sv
// Round-robin scheduler that time-shares one fixed-latency psi_fpt_core among NUM_CH channels,
// routing each correction/veto back to the channel that issued the sample.
module fpt_channel_scheduler #(
   parameter int unsigned NUM_CH       = 4,
   parameter int unsigned CORE_LATENCY = 3,
   parameter int unsigned MAX_HOLD     = 2
) (
   input  logic                 clk_250mhz,
   input  logic                 rst,
   input  logic                 lock_in,
   input  logic [NUM_CH*16-1:0] ch_scrape,
   input  logic [NUM_CH*16-1:0] ch_motor,
   input  logic [NUM_CH-1:0]    ch_valid,
   output logic [NUM_CH-1:0]    ch_ready,
   output logic [NUM_CH*16-1:0] ch_correction,
   output logic [NUM_CH-1:0]    ch_corr_valid,
   output logic [NUM_CH-1:0]    ch_veto,
   input  logic [NUM_CH-1:0]    veto_clear,
   output logic [15:0]          core_scrape,
   output logic [15:0]          core_motor,
   output logic                 core_valid,
   input  logic [15:0]          core_correction,
   input  logic                 core_veto,
   input  logic [1:0]           core_attention,
   output logic [2:0]           grant_id,
   output logic                 busy
);

   localparam int unsigned IdxW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned WaitLast = (CORE_LATENCY >= 2) ? CORE_LATENCY - 2 : 0;
   localparam int unsigned CntW     = (CORE_LATENCY > 2) ? $clog2(CORE_LATENCY - 1) : 1;
   localparam int unsigned HoldW    = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

   typedef enum logic [2:0] {StIdle, StArb, StIssue, StWait, StCapture} state_e;

   state_e                state_q, state_d;
   logic [IdxW-1:0]       ptr_q, ptr_d;
   logic [IdxW-1:0]       gid_q, gid_d;
   logic [HoldW-1:0]      hold_q, hold_d;
   logic [1:0]            att_q, att_d;
   logic [CntW-1:0]       wcnt_q, wcnt_d;
   logic                  busy_q, busy_d;
   logic [15:0]           cs_q, cs_d;
   logic [15:0]           cm_q, cm_d;
   logic [NUM_CH*16-1:0]  corr_q, corr_d;
   logic [NUM_CH-1:0]     veto_q, veto_d;

   logic [NUM_CH-1:0]     eligible;
   logic                  rr_found;
   logic [IdxW-1:0]       rr_ch;
   logic [IdxW-1:0]       idx;
   logic                  hold_ok;
   logic [IdxW-1:0]       g;
   logic                  capture;

   assign eligible = ch_valid & ~veto_q;

   // First eligible channel at or after the round-robin pointer.
   always_comb begin
      rr_found = 1'b0;
      rr_ch    = '0;
      idx      = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         idx = IdxW'((32'(ptr_q) + i) % NUM_CH);
         if (!rr_found && eligible[idx]) begin
            rr_found = 1'b1;
            rr_ch    = idx;
         end
      end
   end

   assign hold_ok = (att_q == 2'b11) && eligible[gid_q] && (32'(hold_q) < MAX_HOLD);
   assign g       = hold_ok ? gid_q : rr_ch;

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      gid_d         = gid_q;
      hold_d        = hold_q;
      att_d         = att_q;
      wcnt_d        = wcnt_q;
      busy_d        = busy_q;
      cs_d          = cs_q;
      cm_d          = cm_q;
      corr_d        = corr_q;
      veto_d        = veto_q & ~veto_clear;
      ch_ready      = '0;
      ch_corr_valid = '0;
      core_valid    = 1'b0;
      capture       = 1'b0;

      // Losing lock abandons any transaction without touching results or the pointer.
      if (!lock_in) begin
         state_d = StIdle;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            StIdle: state_d = StArb;
            StArb: begin
               if (|eligible) begin
                  ch_ready = NUM_CH'(1) << g;
                  cs_d     = ch_scrape[32'(g)*16 +: 16];
                  cm_d     = ch_motor[32'(g)*16 +: 16];
                  gid_d    = g;
                  busy_d   = 1'b1;
                  hold_d   = hold_ok ? hold_q + 1'b1 : '0;
                  state_d  = StIssue;
               end
            end
            StIssue: begin
               core_valid = 1'b1;
               wcnt_d     = '0;
               state_d    = (CORE_LATENCY == 1) ? StCapture : StWait;
            end
            StWait: begin
               if (wcnt_q == CntW'(WaitLast)) state_d = StCapture;
               else                           wcnt_d  = wcnt_q + 1'b1;
            end
            StCapture: begin
               capture                         = 1'b1;
               ch_corr_valid[gid_q]            = 1'b1;
               corr_d[32'(gid_q)*16 +: 16]     = core_correction;
               if (core_veto) veto_d[gid_q]    = 1'b1;
               att_d   = core_attention;
               ptr_d   = (32'(gid_q) == NUM_CH - 1) ? '0 : gid_q + 1'b1;
               busy_d  = 1'b0;
               state_d = StArb;
            end
            default: state_d = StIdle;
         endcase
      end

      if (rst) begin
         ch_ready      = '0;
         ch_corr_valid = '0;
         core_valid    = 1'b0;
         capture       = 1'b0;
      end
   end

   // The freshly captured word is forwarded so it is valid alongside its pulse.
   always_comb begin
      ch_correction = corr_q;
      if (capture) ch_correction[32'(gid_q)*16 +: 16] = core_correction;
   end

   always_ff @(posedge clk_250mhz) begin
      if (rst) begin
         state_q <= StIdle;
         ptr_q   <= '0;
         gid_q   <= '0;
         hold_q  <= '0;
         att_q   <= '0;
         wcnt_q  <= '0;
         busy_q  <= 1'b0;
         cs_q    <= '0;
         cm_q    <= '0;
         corr_q  <= '0;
         veto_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gid_q   <= gid_d;
         hold_q  <= hold_d;
         att_q   <= att_d;
         wcnt_q  <= wcnt_d;
         busy_q  <= busy_d;
         cs_q    <= cs_d;
         cm_q    <= cm_d;
         corr_q  <= corr_d;
         veto_q  <= veto_d;
      end
   end

   assign ch_veto     = veto_q;
   assign core_scrape = cs_q;
   assign core_motor  = cm_q;
   assign grant_id    = 3'(gid_q);
   assign busy        = busy_q;

endmodule

// File: tb/tb_fpt_channel_scheduler.sv
// Scoreboard bench: two schedulers (latency 3 and latency 1) driving a behavioural core model.
module tb_fpt_channel_scheduler;
   localparam int N = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst, lock0, lock1;
   logic [N*16-1:0] scrape, motor;
   logic [N-1:0]    valid0, valid1, vclr0, vclr1;
   logic [N-1:0]    rdy0, rdy1, cv0, cv1, veto0, veto1;
   logic [N*16-1:0] corr0, corr1;
   logic [15:0]     cs0, cm0, cs1, cm1, cc0, cc1;
   logic            corev0, corev1, cveto0, cveto1, busy0, busy1;
   logic [1:0]      catt0, catt1;
   logic [2:0]      gid0, gid1;

   logic [N-1:0]    veto_arm;
   logic [1:0]      att_arm [N];

   // Core model: result is a fixed function of the issued words; veto/attention chosen per channel.
   assign cc0    = cs0 ^ cm0;
   assign cveto0 = veto_arm[cs0[1:0]];
   assign catt0  = att_arm[cs0[1:0]];
   assign cc1    = cs1 ^ cm1;
   assign cveto1 = 1'b0;
   assign catt1  = 2'b00;

   fpt_channel_scheduler #(.NUM_CH(N), .CORE_LATENCY(3), .MAX_HOLD(2)) dut0 (
      .clk_250mhz(clk), .rst(rst), .lock_in(lock0), .ch_scrape(scrape), .ch_motor(motor),
      .ch_valid(valid0), .ch_ready(rdy0), .ch_correction(corr0), .ch_corr_valid(cv0),
      .ch_veto(veto0), .veto_clear(vclr0), .core_scrape(cs0), .core_motor(cm0),
      .core_valid(corev0), .core_correction(cc0), .core_veto(cveto0),
      .core_attention(catt0), .grant_id(gid0), .busy(busy0));

   fpt_channel_scheduler #(.NUM_CH(N), .CORE_LATENCY(1), .MAX_HOLD(2)) dut1 (
      .clk_250mhz(clk), .rst(rst), .lock_in(lock1), .ch_scrape(scrape), .ch_motor(motor),
      .ch_valid(valid1), .ch_ready(rdy1), .ch_correction(corr1), .ch_corr_valid(cv1),
      .ch_veto(veto1), .veto_clear(vclr1), .core_scrape(cs1), .core_motor(cm1),
      .core_valid(corev1), .core_correction(cc1), .core_veto(cveto1),
      .core_attention(catt1), .grant_id(gid1), .busy(busy1));

   typedef struct {
      int ch;
      int gap;
      bit corr;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;
   int   last_g  [2];
   int   pend_ch [2];
   bit   pend    [2];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] exp_corr(input int ch);
      logic [15:0] s, m;
      s = 16'h1230 | 16'(ch);
      m = 16'h0004 | (16'(ch) << 8);
      return s ^ m;
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int u, input int ch, input int gap, input bit corr);
      exp_t e;
      e.ch = ch; e.gap = gap; e.corr = corr;
      if (u == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   task automatic mon(input int u, input logic [N-1:0] rdy, input logic [N-1:0] cv,
                      input logic [N*16-1:0] corr, input logic [2:0] gid);
      exp_t e;
      int   lat;
      lat = (u == 0) ? 4 : 2;
      if (rdy != '0) begin
         chk($sformatf("u%0d_corr_missing", u), longint'(pend[u]), 0);
         if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
            chk($sformatf("u%0d_unexpected_grant", u), longint'(rdy), 0);
         end else begin
            e = (u == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("u%0d_grant_ch", u), longint'(rdy), longint'(1 << e.ch));
            if (e.gap != 0) chk($sformatf("u%0d_grant_gap", u), cyc - last_g[u], e.gap);
            last_g[u]  = cyc;
            pend[u]    = e.corr;
            pend_ch[u] = e.ch;
         end
      end
      if (cv != '0) begin
         chk($sformatf("u%0d_corr_expected", u), longint'(pend[u]), 1);
         if (pend[u]) begin
            chk($sformatf("u%0d_corr_ch", u), longint'(cv), longint'(1 << pend_ch[u]));
            chk($sformatf("u%0d_corr_latency", u), cyc - last_g[u], lat);
            chk($sformatf("u%0d_corr_data", u), longint'(corr[pend_ch[u]*16 +: 16]),
                longint'(exp_corr(pend_ch[u])));
            chk($sformatf("u%0d_corr_gid", u), longint'(gid), pend_ch[u]);
            pend[u] = 1'b0;
         end
      end
   endtask

   always @(negedge clk) begin
      mon(0, rdy0, cv0, corr0, gid0);
      mon(1, rdy1, cv1, corr1, gid1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_grant(input int u);
      bit got;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         tick();
         if ((u == 0 && rdy0 != '0) || (u == 1 && rdy1 != '0)) got = 1'b1;
      end
      chk($sformatf("u%0d_grant_timeout", u), longint'(got), 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      rst = 1'b1; lock0 = 1'b0; lock1 = 1'b1;
      valid0 = '0; valid1 = '0; vclr0 = '0; vclr1 = '0; veto_arm = '0;
      for (int i = 0; i < N; i++) begin
         scrape[i*16 +: 16] = 16'h1230 | 16'(i);
         motor[i*16 +: 16]  = 16'h0004 | (16'(i) << 8);
         att_arm[i]         = 2'b00;
      end
      for (int u = 0; u < 2; u++) begin
         last_g[u] = 0; pend[u] = 1'b0; pend_ch[u] = 0;
      end

      // Reset state
      tick(); tick();
      chk("rst_ready", longint'(rdy0), 0);
      chk("rst_veto", longint'(veto0), 0);
      chk("rst_busy", longint'(busy0), 0);
      chk("rst_core_valid", longint'(corev0), 0);
      chk("rst_grant_id", longint'(gid0), 0);
      chk("rst_corr", longint'(corr0 != '0), 0);
      chk("rst_core_scrape", longint'(cs0), 0);

      // Lock gating
      valid0 = 4'b1111; rst = 1'b0;
      cnt = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (rdy0 != '0) cnt++;
      end
      chk("no_ready_unlocked", cnt, 0);

      // Round robin 0,1,2,3,0
      push(0, 0, 0, 1); push(0, 1, 5, 1); push(0, 2, 5, 1); push(0, 3, 5, 1); push(0, 0, 5, 1);
      lock0 = 1'b1;
      tick();
      chk("first_ready", longint'(rdy0), 1);
      tick();
      chk("issue_core_valid", longint'(corev0), 1);
      chk("issue_busy", longint'(busy0), 1);
      chk("issue_core_scrape", longint'(cs0), 16'h1230);
      tick();
      chk("wait_core_valid", longint'(corev0), 0);
      for (int k = 0; k < 4; k++) wait_grant(0);

      // Veto on channel 1: skipped until cleared
      push(0, 1, 5, 1); push(0, 2, 5, 1); push(0, 3, 5, 1); push(0, 0, 5, 1); push(0, 2, 5, 1);
      veto_arm[1] = 1'b1;
      wait_grant(0);
      wait_grant(0);
      chk("veto_set", longint'(veto0), 4'b0010);
      veto_arm[1] = 1'b0;
      for (int k = 0; k < 3; k++) wait_grant(0);
      push(0, 3, 5, 1); push(0, 0, 5, 1); push(0, 1, 5, 1);
      vclr0 = 4'b0010;
      tick();
      chk("veto_cleared", longint'(veto0), 0);
      vclr0 = '0;
      for (int k = 0; k < 3; k++) wait_grant(0);

      // Set and clear in the same cycle: set wins
      veto_arm[1] = 1'b1;
      push(0, 2, 5, 1);
      for (int k = 0; k < 4; k++) tick();
      chk("capture_align", longint'(cv0), 4'b0010);
      vclr0 = 4'b0010;
      tick();
      chk("veto_set_wins", longint'(veto0), 4'b0010);
      veto_arm[1] = 1'b0;
      tick();
      chk("veto_clear_after", longint'(veto0), 0);
      vclr0 = '0; valid0 = '0;
      for (int k = 0; k < 8; k++) tick();

      // Attention hold: channel 2 three times, then 3
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      push(0, 0, 0, 1); push(0, 1, 5, 1); push(0, 2, 5, 1); push(0, 2, 5, 1);
      push(0, 2, 5, 1); push(0, 3, 5, 1); push(0, 0, 5, 1);
      att_arm[2] = 2'b11;
      valid0 = 4'b1111;
      for (int k = 0; k < 7; k++) wait_grant(0);
      att_arm[2] = 2'b00;

      // Lock drop during channel 3's wait; channel 3 re-offered first
      push(0, 1, 5, 1); push(0, 2, 5, 1); push(0, 3, 5, 0);
      for (int k = 0; k < 3; k++) wait_grant(0);
      tick(); tick();
      chk("wait_busy", longint'(busy0), 1);
      lock0 = 1'b0;
      tick();
      chk("drop_core_valid", longint'(corev0), 0);
      chk("drop_busy", longint'(busy0), 0);
      push(0, 3, 0, 1); push(0, 0, 5, 1);
      for (int k = 0; k < 4; k++) tick();
      lock0 = 1'b1;
      wait_grant(0);
      wait_grant(0);
      tick();
      valid0 = '0;
      for (int k = 0; k < 8; k++) tick();

      // Single channel, latency 1: grants every 3 cycles
      push(1, 2, 0, 1); push(1, 2, 3, 1); push(1, 2, 3, 1); push(1, 2, 3, 1);
      valid1 = 4'b0100;
      for (int k = 0; k < 3; k++) begin
         wait_grant(1);
         chk("single_grant_id", longint'(gid1), 2);
      end
      tick();
      valid1 = '0;
      for (int k = 0; k < 6; k++) tick();

      chk("q0_drained", q0.size(), 0);
      chk("q1_drained", q1.size(), 0);
      chk("u0_pending", longint'(pend[0]), 0);
      chk("u1_pending", longint'(pend[1]), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
